stopwatch_bcd: RTL and testbench
================================

// Module: stopwatch_bcd
// PURPOSE
//   Stopwatch consuming the 10 Hz single-cycle rollover pulse produced by a counter_mod_k_ro
//   stage on the 50 MHz clock. Keeps elapsed time as BCD digits M:SS.t with start/stop, lap
//   (display freeze) and clear control. Digit outputs feed the downstream 7-segment decoders.
//   The state machine runs on the 50 MHz clock; all counting is gated by the tick enable.
// PARAMETERS
//   MAX_MIN  9  highest minute value before wrap (legal range 1..9)
// PORTS
//   clk         in   1  system clock (MAX10_CLK1_50 at top level)
//   reset       in   1  asynchronous, active-high reset
//   tick        in   1  10 Hz enable, high for exactly one clk cycle per period
//   start_stop  in   1  single-cycle command pulse: toggles running/paused
//   lap         in   1  single-cycle command pulse: toggles display freeze while running
//   clear       in   1  single-cycle command pulse: zero the count when paused
//   d_tenth     out  4  displayed tenths digit, 0..9
//   d_sec_u     out  4  displayed seconds units digit, 0..9
//   d_sec_t     out  4  displayed seconds tens digit, 0..5
//   d_min       out  4  displayed minutes digit, 0..MAX_MIN
//   running     out  1  high in RUN and LAP
//   lap_active  out  1  high in LAP (display frozen)
//   overflow    out  1  sticky: count wrapped past MAX_MIN:59.9
// BEHAVIOUR
//   Reset (async, no clk edge needed): state=IDLE, internal count=0:00.0, all d_*=0,
//     running=0, lap_active=0, overflow=0.
//   States and transitions; at most one per cycle; priority clear > start_stop > lap.
//     IDLE:   start_stop->RUN. lap and clear ignored.
//     RUN:    start_stop->PAUSED; lap->LAP; clear ignored.
//     LAP:    start_stop->PAUSED (display released); lap->RUN; clear ignored.
//     PAUSED: clear->IDLE (count:=0, overflow:=0); start_stop->RUN; lap ignored.
//   Counting: count advances on a clk edge where tick=1 and the pre-edge state is RUN or LAP.
//     - A tick coincident with start_stop leaving RUN/LAP is counted.
//     - A tick coincident with start_stop entering RUN from IDLE/PAUSED is not counted.
//   Digit arithmetic (BCD ripple in one cycle, no binary intermediate):
//     tenth 9->0 carries to sec_u; sec_u 9->0 carries to sec_t; sec_t 5->0 carries to min.
//     min==MAX_MIN with a carry in -> min=0, i.e. full wrap to 0:00.0. overflow:=1 on the
//     same edge and holds until clear (PAUSED) or reset.
//   Display: d_* are registered. In IDLE/RUN/PAUSED they load the next count on every edge,
//     so they match the internal count with zero extra latency.
//     On the edge that enters LAP they load the count as updated on that edge (including a
//     coincident tick), then hold while count keeps advancing.
//     On leaving LAP (either exit) they load the live count on that edge.
//   running and lap_active are registered and reflect the post-edge state.
//   Commands and tick are single-cycle pulses. A level held N cycles acts as N commands
//     (start_stop toggles every cycle); debouncing and edge detection are done upstream.
//   Reset mid-operation aborts immediately; no partial-carry state may survive.
// TESTING
//   1. reset; start_stop; 100 ticks -> d=0:10.0, running=1, overflow=0.
//   2. MAX_MIN=9; run 5999 ticks -> 9:59.9; 1 more tick -> 0:00.0, overflow=1; continues counting.
//   3. start; 25 ticks; lap; 30 ticks -> d=0:02.5, lap_active=1; lap -> d=0:05.5, lap_active=0.
//   4. start; 7 ticks; start_stop; 10 ticks -> d=0:00.7 (no count); clear -> IDLE, d=0:00.0, overflow=0.
//   5. Simultaneous events: tick+start_stop in RUN at 0:00.3 -> PAUSED at 0:00.4;
//      clear+start_stop in PAUSED -> IDLE, count=0; tick+start_stop in IDLE -> RUN, count stays 0:00.0.
//   6. Assert reset between clk edges during RUN at 1:23.4 -> all outputs 0 before next edge;
//      release reset -> IDLE, ticks ignored.

Source files
------------

// File: rtl/stopwatch_bcd.sv
// Stopwatch with BCD time digits M:SS.t, driven by a 10 Hz tick enable.
// Supports start/stop, lap (display freeze while counting continues) and clear.
module stopwatch_bcd #(
    parameter int unsigned MAX_MIN = 9
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       start_stop,
    input  logic       lap,
    input  logic       clear,
    output logic [3:0] d_tenth,
    output logic [3:0] d_sec_u,
    output logic [3:0] d_sec_t,
    output logic [3:0] d_min,
    output logic       running,
    output logic       lap_active,
    output logic       overflow
);

    localparam logic [3:0] MAX_MIN_D = 4'(MAX_MIN);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_LAP,
        S_PAUSED
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] tenth_q, tenth_d;
    logic [3:0] sec_u_q, sec_u_d;
    logic [3:0] sec_t_q, sec_t_d;
    logic [3:0] min_q,   min_d;
    logic       overflow_q, overflow_d;
    logic [3:0] disp_tenth_q, disp_tenth_d;
    logic [3:0] disp_sec_u_q, disp_sec_u_d;
    logic [3:0] disp_sec_t_q, disp_sec_t_d;
    logic [3:0] disp_min_q,   disp_min_d;
    logic       running_q, running_d;
    logic       lap_active_q, lap_active_d;

    logic count_en;
    logic do_clear;

    // Counting uses the pre-edge state, so a tick leaving RUN/LAP counts and one entering RUN does not.
    assign count_en = tick && ((state_q == S_RUN) || (state_q == S_LAP));
    assign do_clear = (state_q == S_PAUSED) && clear;

    // Next-state logic: clear has priority over start_stop, which has priority over lap.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (start_stop) state_d = S_RUN;
            end
            S_RUN: begin
                if (start_stop)  state_d = S_PAUSED;
                else if (lap)    state_d = S_LAP;
            end
            S_LAP: begin
                if (start_stop)  state_d = S_PAUSED;
                else if (lap)    state_d = S_RUN;
            end
            S_PAUSED: begin
                if (clear)           state_d = S_IDLE;
                else if (start_stop) state_d = S_RUN;
            end
            default: state_d = S_IDLE;
        endcase
        running_d    = (state_d == S_RUN) || (state_d == S_LAP);
        lap_active_d = (state_d == S_LAP);
    end

    // BCD ripple increment of the live count, with wrap/overflow and clear.
    always_comb begin
        tenth_d    = tenth_q;
        sec_u_d    = sec_u_q;
        sec_t_d    = sec_t_q;
        min_d      = min_q;
        overflow_d = overflow_q;
        if (do_clear) begin
            tenth_d    = '0;
            sec_u_d    = '0;
            sec_t_d    = '0;
            min_d      = '0;
            overflow_d = 1'b0;
        end else if (count_en) begin
            if (tenth_q == 4'd9) begin
                tenth_d = '0;
                if (sec_u_q == 4'd9) begin
                    sec_u_d = '0;
                    if (sec_t_q == 4'd5) begin
                        sec_t_d = '0;
                        if (min_q == MAX_MIN_D) begin
                            min_d      = '0;
                            overflow_d = 1'b1;
                        end else begin
                            min_d = min_q + 4'd1;
                        end
                    end else begin
                        sec_t_d = sec_t_q + 4'd1;
                    end
                end else begin
                    sec_u_d = sec_u_q + 4'd1;
                end
            end else begin
                tenth_d = tenth_q + 4'd1;
            end
        end
    end

    // Display tracks the next count except while remaining in LAP, where it holds.
    always_comb begin
        disp_tenth_d = tenth_d;
        disp_sec_u_d = sec_u_d;
        disp_sec_t_d = sec_t_d;
        disp_min_d   = min_d;
        if ((state_q == S_LAP) && (state_d == S_LAP)) begin
            disp_tenth_d = disp_tenth_q;
            disp_sec_u_d = disp_sec_u_q;
            disp_sec_t_d = disp_sec_t_q;
            disp_min_d   = disp_min_q;
        end
    end

    // State, count and display registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            tenth_q      <= '0;
            sec_u_q      <= '0;
            sec_t_q      <= '0;
            min_q        <= '0;
            overflow_q   <= 1'b0;
            disp_tenth_q <= '0;
            disp_sec_u_q <= '0;
            disp_sec_t_q <= '0;
            disp_min_q   <= '0;
            running_q    <= 1'b0;
            lap_active_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            tenth_q      <= tenth_d;
            sec_u_q      <= sec_u_d;
            sec_t_q      <= sec_t_d;
            min_q        <= min_d;
            overflow_q   <= overflow_d;
            disp_tenth_q <= disp_tenth_d;
            disp_sec_u_q <= disp_sec_u_d;
            disp_sec_t_q <= disp_sec_t_d;
            disp_min_q   <= disp_min_d;
            running_q    <= running_d;
            lap_active_q <= lap_active_d;
        end
    end

    assign d_tenth    = disp_tenth_q;
    assign d_sec_u    = disp_sec_u_q;
    assign d_sec_t    = disp_sec_t_q;
    assign d_min      = disp_min_q;
    assign running    = running_q;
    assign lap_active = lap_active_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_stopwatch_bcd.sv
// Bench for stopwatch_bcd: directed scenarios plus random command/tick pulses,
// compared every cycle against a reference that keeps time as total tenths.
module tb_stopwatch_bcd;

    localparam int unsigned MAX_MIN = 9;
    localparam int LIMIT = (MAX_MIN + 1) * 600;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tick = 1'b0, start_stop = 1'b0, lap = 1'b0, clear = 1'b0;
    logic [3:0] d_tenth, d_sec_u, d_sec_t, d_min;
    logic       running, lap_active, overflow;

    stopwatch_bcd #(.MAX_MIN(MAX_MIN)) dut (
        .clk(clk), .reset(reset), .tick(tick), .start_stop(start_stop),
        .lap(lap), .clear(clear), .d_tenth(d_tenth), .d_sec_u(d_sec_u),
        .d_sec_t(d_sec_t), .d_min(d_min), .running(running),
        .lap_active(lap_active), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference: elapsed time as an integer count of tenths, plus mode flags.
    int m_total, m_frozen;
    bit m_run, m_lap, m_paused, m_ovf;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    endtask

    function automatic logic [15:0] to_bcd(input int v);
        logic [3:0] m, st, su, te;
        m  = 4'(v / 600);
        st = 4'((v % 600) / 100);
        su = 4'((v % 100) / 10);
        te = 4'(v % 10);
        return {m, st, su, te};
    endfunction

    function automatic logic [15:0] dut_disp();
        return {d_min, d_sec_t, d_sec_u, d_tenth};
    endfunction

    task automatic model_reset();
        m_total = 0; m_frozen = 0;
        m_run = 0; m_lap = 0; m_paused = 0; m_ovf = 0;
    endtask

    task automatic model_step(input bit t, input bit s, input bit l, input bit c);
        if (m_run && t) begin
            m_total++;
            if (m_total == LIMIT) begin
                m_total = 0;
                m_ovf = 1;
            end
        end
        if (m_paused && c) begin
            m_paused = 0; m_total = 0; m_ovf = 0;
        end else if (s) begin
            if (m_run) begin
                m_run = 0; m_lap = 0; m_paused = 1;
            end else begin
                m_run = 1; m_paused = 0;
            end
        end else if (l && m_run) begin
            m_lap = !m_lap;
            if (m_lap) m_frozen = m_total;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_disp"}, {16'h0, dut_disp()}, {16'h0, to_bcd(m_lap ? m_frozen : m_total)});
        chk({tag, "_flags"}, {29'h0, running, lap_active, overflow}, {29'h0, m_run, m_lap, m_ovf});
    endtask

    // One clock cycle: drive pulses at negedge, advance model at posedge, sample 1 ns later.
    task automatic cyc(input bit t, input bit s, input bit l, input bit c);
        @(negedge clk);
        tick = t; start_stop = s; lap = l; clear = c;
        @(posedge clk);
        model_step(t, s, l, c);
        #1;
        check_all("cyc");
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) cyc(1, 0, 0, 0);
    endtask

    // Reset asserted between clock edges; outputs must clear without an edge.
    task automatic do_reset();
        @(negedge clk);
        tick = 0; start_stop = 0; lap = 0; clear = 0;
        reset = 1'b1;
        #1;
        model_reset();
        chk("rst_disp", {16'h0, dut_disp()}, 32'h0);
        chk("rst_flags", {29'h0, running, lap_active, overflow}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        model_reset();
        #1;
        chk("por_disp", {16'h0, dut_disp()}, 32'h0);
        chk("por_flags", {29'h0, running, lap_active, overflow}, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        // 1: 100 ticks -> 0:10.0
        do_reset();
        cyc(0, 1, 0, 0);
        for (int i = 0; i < 100; i++) begin cyc(1, 0, 0, 0); cyc(0, 0, 0, 0); end
        chk("t1_disp", {16'h0, dut_disp()}, 32'h0100);
        chk("t1_run_ovf", {30'h0, running, overflow}, 32'h2);

        // 2: full range then wrap with overflow
        do_reset();
        cyc(0, 1, 0, 0);
        ticks(5999);
        chk("t2_max", {16'h0, dut_disp()}, 32'h9599);
        chk("t2_ovf0", {31'h0, overflow}, 32'h0);
        cyc(1, 0, 0, 0);
        chk("t2_wrap", {16'h0, dut_disp()}, 32'h0000);
        chk("t2_ovf1", {31'h0, overflow}, 32'h1);
        ticks(12);
        chk("t2_cont", {16'h0, dut_disp()}, 32'h0012);
        chk("t2_sticky", {31'h0, overflow}, 32'h1);

        // 3: lap freezes display while counting continues
        do_reset();
        cyc(0, 1, 0, 0);
        ticks(25);
        cyc(0, 0, 1, 0);
        ticks(30);
        chk("t3_frozen", {16'h0, dut_disp()}, 32'h0025);
        chk("t3_lapact", {31'h0, lap_active}, 32'h1);
        cyc(0, 0, 1, 0);
        chk("t3_release", {16'h0, dut_disp()}, 32'h0055);
        chk("t3_lapoff", {31'h0, lap_active}, 32'h0);

        // 4: pause ignores ticks; clear returns to zero
        do_reset();
        cyc(0, 1, 0, 0);
        ticks(7);
        cyc(0, 1, 0, 0);
        ticks(10);
        chk("t4_paused", {16'h0, dut_disp()}, 32'h0007);
        cyc(0, 0, 0, 1);
        chk("t4_clear", {16'h0, dut_disp()}, 32'h0000);
        chk("t4_flags", {29'h0, running, lap_active, overflow}, 32'h0);

        // 5: coincident events
        do_reset();
        cyc(0, 1, 0, 0);
        ticks(3);
        cyc(1, 1, 0, 0);
        chk("t5_stop_tick", {16'h0, dut_disp()}, 32'h0004);
        chk("t5_paused", {31'h0, running}, 32'h0);
        cyc(0, 1, 0, 1);
        chk("t5_clr_prio", {15'h0, running, dut_disp()}, 32'h0);
        cyc(1, 1, 0, 0);
        chk("t5_start_tick", {15'h0, running, dut_disp()}, 32'h10000);

        // 6: reset mid-run at 1:23.4, ticks ignored afterwards
        do_reset();
        cyc(0, 1, 0, 0);
        ticks(834);
        chk("t6_pre", {16'h0, dut_disp()}, 32'h1234);
        do_reset();
        ticks(5);
        chk("t6_idle", {15'h0, running, dut_disp()}, 32'h0);

        // Random pulse mix against the reference
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            cyc($urandom_range(0, 99) < 40, $urandom_range(0, 99) < 3,
                $urandom_range(0, 99) < 4, $urandom_range(0, 99) < 6);
        end
        idle_cycles(2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
